// File: rtl/servo_pwm_ctrl.sv
// rtl/servo_pwm_ctrl.sv - 8-bit position commands to slew-limited servo PWM frames
// Optional watchdog failsafe is built when SERVO_FAILSAFE_EN is defined.
module servo_pwm_ctrl #(
  parameter int CLK_FREQ     = 100000000,
  parameter int PWM_FREQ     = 50,
  parameter int MIN_PULSE_US = 1000,
  parameter int MAX_PULSE_US = 2000,
  parameter int SLEW_STEP    = 4,
  parameter int WDOG_FRAMES  = 50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_pos,
  output logic       cmd_ready,
  output logic       servo_out,
  output logic [7:0] cur_pos,
  output logic       at_target,
  output logic       frame_tick,
  output logic       failsafe
);
  localparam int FRAME_CYC = CLK_FREQ / PWM_FREQ;
  localparam int MIN_CYC   = (CLK_FREQ / 1000000) * MIN_PULSE_US;
  localparam int MAX_CYC   = (CLK_FREQ / 1000000) * MAX_PULSE_US;
  localparam int SPAN_CYC  = MAX_CYC - MIN_CYC;
  localparam int CW        = $clog2(FRAME_CYC);
  localparam int PW_W      = $clog2(MAX_CYC + 1);
  localparam int PROD_W    = PW_W + 8;
  localparam int PW_RESET  = MIN_CYC + ((128 * SPAN_CYC) >> 8);

  typedef enum logic [1:0] {DISABLED, PULSE, REST} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     count;
  logic [PW_W-1:0]   pw, pw_next;
  logic [7:0]        target, target_next, pos_next, pending;
  logic              pending_full, boundary, accept, wdog_trip;
  logic [PROD_W-1:0] prod;

  assign boundary   = (count == CW'(FRAME_CYC - 1));
  assign accept     = cmd_valid && !pending_full;
  assign cmd_ready  = !pending_full;
  assign frame_tick = boundary;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)         count <= '0;
    else if (boundary) count <= '0;
    else               count <= count + CW'(1);
  end

  // New target, one slew step toward it, and the pulse width of the coming frame
  always_comb begin
    target_next = pending_full ? pending : target;
    if (wdog_trip) target_next = 8'd128;
    pos_next = target_next;
    if (SLEW_STEP != 0) begin
      if (target_next > cur_pos && (target_next - cur_pos) > 8'(SLEW_STEP))
        pos_next = cur_pos + 8'(SLEW_STEP);
      else if (cur_pos > target_next && (cur_pos - target_next) > 8'(SLEW_STEP))
        pos_next = cur_pos - 8'(SLEW_STEP);
    end
    prod    = PROD_W'(pos_next) * PROD_W'(SPAN_CYC);
    pw_next = PW_W'(prod >> 8) + PW_W'(MIN_CYC);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_full <= 1'b0;
      pending      <= 8'd0;
      target       <= 8'd128;
      cur_pos      <= 8'd128;
      at_target    <= 1'b1;
      pw           <= PW_W'(PW_RESET);
    end else begin
      if (boundary) begin
        target    <= target_next;
        cur_pos   <= pos_next;
        pw        <= pw_next;
        at_target <= (pos_next == target_next);
      end
      // A command accepted in the boundary cycle waits for the following boundary
      if (boundary && pending_full) begin
        pending_full <= 1'b0;
      end else if (accept) begin
        pending_full <= 1'b1;
        pending      <= cmd_pos;
      end
    end
  end

`ifdef SERVO_FAILSAFE_EN
  localparam int WW = $clog2(WDOG_FRAMES + 1);
  logic [WW-1:0] wdog_cnt;
  logic          fs_q;

  assign wdog_trip = boundary && !accept && (wdog_cnt == WW'(WDOG_FRAMES - 1));
  assign failsafe  = fs_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wdog_cnt <= '0;
      fs_q     <= 1'b0;
    end else if (accept) begin
      wdog_cnt <= '0;
      fs_q     <= 1'b0;
    end else if (boundary && wdog_cnt != WW'(WDOG_FRAMES)) begin
      wdog_cnt <= wdog_cnt + WW'(1);
      if (wdog_trip) fs_q <= 1'b1;
    end
  end
`else
  assign wdog_trip = 1'b0;
  assign failsafe  = (WDOG_FRAMES < 0);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= DISABLED;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      DISABLED, REST: if (boundary) state_next = enable ? PULSE : DISABLED;
      PULSE:          if (32'(count) + 32'd1 == 32'(pw)) state_next = REST;
      default:        state_next = DISABLED;
    endcase
  end

  always_comb begin
    servo_out = (state == PULSE);
  end
endmodule

// File: tb/tb_servo_pwm_ctrl.sv
// tb/tb_servo_pwm_ctrl.sv - directed tables and randomized run against a frame-level model
// Two instances share stimulus: index 0 uses SLEW_STEP=4, index 1 uses SLEW_STEP=0.
module tb_servo_pwm_ctrl;
  localparam int CLK_FREQ = 1000000;
  localparam int PWM_FREQ = 2500;
  localparam int MIN_US   = 100;
  localparam int MAX_US   = 200;
  localparam int WDOG     = 3;
  localparam int F        = CLK_FREQ / PWM_FREQ;
  localparam int MINC     = (CLK_FREQ / 1000000) * MIN_US;
  localparam int SPAN     = (CLK_FREQ / 1000000) * MAX_US - MINC;

  typedef struct { int pos; int pw; } vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_pos = 8'd0;
  logic [1:0] ready_v, servo_v, at_v, tick_v, fs_v;
  logic [7:0] pos_v [2];

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  servo_pwm_ctrl #(.CLK_FREQ(CLK_FREQ), .PWM_FREQ(PWM_FREQ), .MIN_PULSE_US(MIN_US),
                   .MAX_PULSE_US(MAX_US), .SLEW_STEP(4), .WDOG_FRAMES(WDOG)) dut_s4 (
    .clock(clock), .reset(reset), .enable(enable), .cmd_valid(cmd_valid), .cmd_pos(cmd_pos),
    .cmd_ready(ready_v[0]), .servo_out(servo_v[0]), .cur_pos(pos_v[0]), .at_target(at_v[0]),
    .frame_tick(tick_v[0]), .failsafe(fs_v[0]));

  servo_pwm_ctrl #(.CLK_FREQ(CLK_FREQ), .PWM_FREQ(PWM_FREQ), .MIN_PULSE_US(MIN_US),
                   .MAX_PULSE_US(MAX_US), .SLEW_STEP(0), .WDOG_FRAMES(WDOG)) dut_s0 (
    .clock(clock), .reset(reset), .enable(enable), .cmd_valid(cmd_valid), .cmd_pos(cmd_pos),
    .cmd_ready(ready_v[1]), .servo_out(servo_v[1]), .cur_pos(pos_v[1]), .at_target(at_v[1]),
    .frame_tick(tick_v[1]), .failsafe(fs_v[1]));

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int step_of(int i);
    return (i == 0) ? 4 : 0;
  endfunction

  function automatic int pw_of(int p);
    return MINC + (p * SPAN) / 256;
  endfunction

  function automatic int slew(int p, int t, int s);
    if (s == 0 || ((t - p) <= s && (p - t) <= s)) return t;
    return (t > p) ? p + s : p - s;
  endfunction

  // Frame-level reference: state changes only at boundaries, pulse is a window at frame start
  int cyc, pend, tgt, ph;
  int pos [2];
  int pw [2];
  bit at [2];
  bit pend_full, frame_en, fs, acc, bnd;
`ifdef SERVO_FAILSAFE_EN
  int wd;
`endif

  always @(posedge clock) begin
    if (reset) begin
      cyc = 0; pend_full = 0; pend = 0; tgt = 128; frame_en = 0; fs = 0;
`ifdef SERVO_FAILSAFE_EN
      wd = 0;
`endif
      for (int i = 0; i < 2; i++) begin pos[i] = 128; pw[i] = pw_of(128); at[i] = 1; end
    end else begin
      acc = cmd_valid && !pend_full;
      bnd = (cyc % F) == F - 1;
      if (bnd) begin
        if (pend_full) tgt = pend;
`ifdef SERVO_FAILSAFE_EN
        if (!acc && wd < WDOG) begin
          wd++;
          if (wd == WDOG) begin tgt = 128; fs = 1; end
        end
`endif
        for (int i = 0; i < 2; i++) begin
          pos[i] = slew(pos[i], tgt, step_of(i));
          pw[i]  = pw_of(pos[i]);
          at[i]  = (pos[i] == tgt);
        end
        frame_en = enable;
      end
`ifdef SERVO_FAILSAFE_EN
      if (acc) begin wd = 0; fs = 0; end
`endif
      if (bnd && pend_full) pend_full = 0;
      else if (acc) begin pend_full = 1; pend = cmd_pos; end
      cyc++;
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      ph = cyc % F;
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("servo_out[%0d]", i), servo_v[i], int'(frame_en && ph < pw[i]));
        chk($sformatf("cur_pos[%0d]", i), pos_v[i], pos[i]);
        chk($sformatf("at_target[%0d]", i), at_v[i], at[i]);
        chk($sformatf("cmd_ready[%0d]", i), ready_v[i], int'(!pend_full));
        chk($sformatf("frame_tick[%0d]", i), tick_v[i], int'(ph == F - 1));
        chk($sformatf("failsafe[%0d]", i), fs_v[i], fs);
      end
    end
  end

  int run [2] = '{0, 0};
  int last_w [2] = '{0, 0};
  int rises [2] = '{0, 0};

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) run[i] = 0;
      else if (servo_v[i]) begin
        if (run[i] == 0) rises[i]++;
        run[i]++;
      end else if (run[i] != 0) begin
        last_w[i] = run[i];
        run[i] = 0;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic goto_phase(int p);
    int n = 0;
    do begin step(); n++; end while ((cyc % F) != p && n < 2 * F);
  endtask

  task automatic send(int p);
    cmd_valid = 1'b1;
    cmd_pos = 8'(p);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    repeat (3) step();
    reset = 1'b0;
  endtask

  vec_t tbl [7];
  int exp_pos [3] = '{132, 136, 140};
  int exp_pw [3]  = '{151, 153, 154};
  int r;

  initial begin
    tbl[0] = '{255, 199}; tbl[1] = '{0, 100};   tbl[2] = '{128, 150}; tbl[3] = '{64, 125};
    tbl[4] = '{3, 101};   tbl[5] = '{200, 178}; tbl[6] = '{77, 130};

    step(); step();
    chk("rst_servo", servo_v[0], 0);
    chk("rst_pos", pos_v[0], 128);
    chk("rst_at", at_v[1], 1);
    chk("rst_ready", ready_v[1], 1);
    chk("rst_tick", tick_v[0], 0);
    chk("rst_fs", fs_v[0], 0);
    enable = 1'b1;
    reset = 1'b0;

    // Idle frames at centre position
    goto_phase(F - 1);
    goto_phase(F - 1);
    chk("t1_width_s4", last_w[0], 150);
    chk("t1_width_s0", last_w[1], 150);
    goto_phase(0);
    chk("t1_pulse_start", servo_v[0], 1);
    goto_phase(F - 1);
    chk("t1_rises", rises[0], 2);

    for (int k = 0; k < 7; k++) begin
      goto_phase(200);
      send(tbl[k].pos);
      chk("t2_ready_low", ready_v[1], 0);
      goto_phase(F - 1);
      chk("t2_ready_bnd", ready_v[1], 0);
      step();
      chk("t2_ready_back", ready_v[1], 1);
      chk("t2_pos", pos_v[1], tbl[k].pos);
      goto_phase(F - 1);
      chk("t2_width", last_w[1], tbl[k].pw);
    end

    do_reset();
    goto_phase(200);
    send(140);
    for (int k = 0; k < 3; k++) begin
      goto_phase(0);
      chk("t3_pos", pos_v[0], exp_pos[k]);
      chk("t3_at", at_v[0], int'(k == 2));
      goto_phase(200);
      send(140);
      goto_phase(F - 1);
      chk("t3_width", last_w[0], exp_pw[k]);
    end

    goto_phase(100);
    send(50);
    send(250);
    chk("t4_ready", ready_v[1], 0);
    goto_phase(0);
    chk("t4_ignored", pos_v[1], 50);
    goto_phase(F - 1);
    send(90);
    chk("t4_bnd_not_yet", pos_v[1], 50);
    chk("t4_bnd_ready", ready_v[1], 0);
    goto_phase(0);
    chk("t4_bnd_applied", pos_v[1], 90);

    goto_phase(20);
    chk("t5_in_pulse", servo_v[1], 1);
    enable = 1'b0;
    goto_phase(F - 1);
    chk("t5_full_width", last_w[1], 135);
    r = rises[1];
    goto_phase(F - 1);
    chk("t5_no_pulse", rises[1], r);
    chk("t5_low", servo_v[1], 0);
    enable = 1'b1;
    goto_phase(0);
    goto_phase(30);
    chk("t5_pre_rst_s4", servo_v[0], 1);
    chk("t5_pre_rst_s0", servo_v[1], 1);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_servo_s4", servo_v[0], 0);
    chk("t5_rst_servo_s0", servo_v[1], 0);
    chk("t5_rst_pos", pos_v[1], 128);
    chk("t5_rst_at", at_v[1], 1);
    chk("t5_rst_ready", ready_v[0], 1);
    chk("t5_rst_tick", tick_v[0], 0);
    repeat (2) step();
    reset = 1'b0;

`ifdef SERVO_FAILSAFE_EN
    goto_phase(100);
    send(200);
    for (int b = 1; b <= 3; b++) begin
      goto_phase(0);
      chk("t6_failsafe", fs_v[0], int'(b == 3));
    end
    chk("t6_pos_s4", pos_v[0], 132);
    chk("t6_pos_s0", pos_v[1], 128);
    send(10);
    chk("t6_cleared", fs_v[0], 0);
`endif

    for (int c = 0; c < 60 * F; c++) begin
      cmd_valid = ($urandom_range(0, 199) == 0);
      cmd_pos = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 499) == 0) enable = ~enable;
      step();
    end
    cmd_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/servo_pwm_ctrl.md
Name: servo_pwm_ctrl

Overview:
- Downstream of the processor: turns 8-bit position commands into a 50 Hz servo PWM waveform.
- Each command is applied at a frame boundary, with a per-frame slew limit so the motor does not jerk.
- One instance per servo channel, clocked by the 100 MHz system clock; its output drives a servo pin at top level.

Parameters:
- CLK_FREQ, 100000000: input clock frequency in Hz.
- PWM_FREQ, 50: frame rate in Hz. FRAME_CYC = CLK_FREQ/PWM_FREQ.
- MIN_PULSE_US, 1000: pulse width at position 0. MIN_CYC = (CLK_FREQ/1000000)*MIN_PULSE_US.
- MAX_PULSE_US, 2000: nominal full-scale pulse width. SPAN_CYC = MAX_CYC - MIN_CYC.
- SLEW_STEP, 4: maximum position change per frame. 0 means an immediate jump.
- WDOG_FRAMES, 50: failsafe timeout in frames. Used only with SERVO_FAILSAFE_EN.

Ports:
- clock  in  1  system clock. Every register is clocked on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  output enable, sampled only at frame boundaries.
- cmd_valid  in  1  command strobe.
- cmd_pos  in  8  target position, 0..255.
- cmd_ready  out  1  high when the pending slot is empty.
- servo_out  out  1  PWM output.
- cur_pos  out  8  current slewed position.
- at_target  out  1  high when cur_pos equals the target.
- frame_tick  out  1  one-cycle pulse on each boundary cycle.
- failsafe  out  1  watchdog tripped. Tied 0 without the macro.

Behaviour:
- Reset values: servo_out=0, cmd_ready=1, cur_pos=128, target=128, pw=MIN_CYC+(128*SPAN_CYC>>8), at_target=1, frame_tick=0, failsafe=0, counter=0, state=DISABLED, pending slot empty.
- Reset asserted mid-pulse drives servo_out low immediately.
- Frame counter:
  - counter width = clog2(FRAME_CYC); counts 0..FRAME_CYC-1 and wraps.
  - The boundary cycle is counter==FRAME_CYC-1; frame_tick is high in that cycle only.
- Handshake:
  - A command is accepted when cmd_valid && cmd_ready; it is latched into pending, and cmd_ready drops the next cycle.
  - cmd_ready stays 0 until the next boundary cycle consumes pending. It is 1 again the following cycle.
  - cmd_valid while cmd_ready=0 is ignored, with no stall or error.
  - An acceptance in the boundary cycle itself is not consumed by that boundary; it applies at the next boundary.
- Boundary cycle updates, all in one cycle:
  - target <= pending if pending is full.
  - cur_pos <= cur_pos moved toward the new target by min(SLEW_STEP, |diff|).
  - pw <= MIN_CYC + ((new cur_pos * SPAN_CYC) >> 8); full-width product, no truncation before the shift. Position 255 therefore gives MAX_CYC - SPAN_CYC/256, not MAX_CYC.
  - at_target <= (new cur_pos == new target).
- Latency: a command accepted in frame N first affects the pulse of frame N+1.
- State machine, advancing on boundaries:
  - DISABLED: servo_out=0. At a boundary goes to PULSE if enable=1, otherwise stays.
  - PULSE: servo_out=1 for exactly pw cycles, starting the cycle after the boundary. Then goes to REST.
  - REST: servo_out=0. At a boundary goes to PULSE if enable=1, otherwise DISABLED.
- enable is ignored between boundaries, so no runt pulses occur; deasserting enable mid-pulse lets that pulse complete.
- Slewing and commands continue while the state is DISABLED.

Optional Feature:
SERVO_FAILSAFE_EN
- Defined:
  - A frame counter counts boundaries since the last accepted command.
  - When it reaches WDOG_FRAMES, at that boundary: target <= 128 (overriding pending), failsafe <= 1.
  - Slewing toward 128 proceeds at SLEW_STEP per frame.
  - The next accepted command clears failsafe and the count on its acceptance cycle.
  - Reset clears both.
- Undefined: no watchdog logic; failsafe is constant 0.

Test Plan (parameters CLK_FREQ=1000000, SLEW_STEP=4; FRAME_CYC=20000, MIN_CYC=1000, SPAN_CYC=1000):
1. Reset release, enable=1, no command -> pulses of exactly 1500 cycles every 20000 cycles; cur_pos=128, at_target=1.
2. SLEW_STEP=0. cmd_pos=255 accepted mid-frame -> next frame pulse is 1996 cycles. cmd_pos=0 -> 1000 cycles. cmd_ready low from the cycle after acceptance through the next boundary.
3. SLEW_STEP=4. cmd_pos=140 from 128 -> cur_pos goes 132, 136, 140 over three frames, with pulses of 1515, 1531, 1546 cycles; at_target rises on the third boundary.
4. Second cmd_valid while cmd_ready=0 -> ignored. A command issued in the boundary cycle -> applied one frame later.
5. enable dropped mid-pulse -> the current pulse completes at full width, then servo_out stays 0. Reset asserted mid-pulse -> servo_out=0 immediately and all outputs return to their reset values.
6. SERVO_FAILSAFE_EN, WDOG_FRAMES=3, target 200 held with no further commands -> failsafe=1 at the 3rd boundary after acceptance, cur_pos slews back toward 128. A new command clears failsafe.
